// File: rtl/fetch_pkg.sv
// Shared constants and next-PC select encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush, otherwise
// captures the fetched word and its PC+4 as a valid instruction.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCPlus4In,
  output logic [31:0] InstrOut,
  output logic [31:0] PCPlus4Out,
  output logic        ValidOut
);

  // Stall outranks flush so a held redirect is re-presented next cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      InstrOut   <= NOP_INSTR;
      PCPlus4Out <= 32'h0;
      ValidOut   <= 1'b0;
    end else if (Stall) begin
      InstrOut   <= InstrOut;
      PCPlus4Out <= PCPlus4Out;
      ValidOut   <= ValidOut;
    end else if (Flush) begin
      InstrOut   <= NOP_INSTR;
      PCPlus4Out <= 32'h0;
      ValidOut   <= 1'b0;
    end else begin
      InstrOut   <= InstrIn;
      PCPlus4Out <= PCPlus4In;
      ValidOut   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, prioritised next-PC select,
// redirect misalignment flag, fetch counter and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] InstrAddr,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        MisalignErr,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        redirect;
  pc_sel_e     sel;

  assign InstrAddr = pc;
  assign pc_plus4  = pc + PC_INCR;

  always_comb begin
    sel = SEL_SEQ;
    if (JumpReg)     sel = SEL_JR;
    else if (Jump)   sel = SEL_J;
    else if (Branch) sel = SEL_BR;
  end

  always_comb begin
    target = pc_plus4;
    case (sel)
      SEL_JR:  target = JumpRegTarget;
      SEL_J:   target = JumpTarget;
      SEL_BR:  target = BranchTarget;
      default: target = pc_plus4;
    endcase
  end

  assign redirect = (sel != SEL_SEQ) && !Stall;

  always_comb begin
    next_pc = pc_plus4;
    if (Stall)         next_pc = pc;
    else if (redirect) next_pc = {target[31:2], 2'b00};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  // Only the chosen target is checked; the flag is a single-cycle pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MisalignErr <= 1'b0;
      FetchCount  <= 32'h0;
    end else begin
      MisalignErr <= redirect && (target[1:0] != 2'b00);
      if (!Stall && !redirect) FetchCount <= FetchCount + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Stall      (Stall),
    .Flush      (redirect),
    .InstrIn    (Instruction),
    .PCPlus4In  (pc_plus4),
    .InstrOut   (IFID_Instruction),
    .PCPlus4Out (IFID_PCPlus4),
    .ValidOut   (IFID_Valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect traffic compared against a behavioural fetch model.
module tb_fetch_stage;

  logic        Clk;
  logic        Rst_n;
  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        JumpReg;
  logic [31:0] JumpRegTarget;
  logic [31:0] Instruction;
  logic [31:0] InstrAddr;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        MisalignErr;
  logic [31:0] FetchCount;

  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;

  logic [31:0] mPc, mIns, mP4, mCnt;
  logic        mValid, mMis;

  fetch_stage dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Stall            (Stall),
    .Branch           (Branch),
    .BranchTarget     (BranchTarget),
    .Jump             (Jump),
    .JumpTarget       (JumpTarget),
    .JumpReg          (JumpReg),
    .JumpRegTarget    (JumpRegTarget),
    .Instruction      (Instruction),
    .InstrAddr        (InstrAddr),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .MisalignErr      (MisalignErr),
    .FetchCount       (FetchCount)
  );

  assign Instruction = mem[InstrAddr[11:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".addr"},  InstrAddr,        mPc);
    checkVal({tag, ".instr"}, IFID_Instruction, mIns);
    checkVal({tag, ".pc4"},   IFID_PCPlus4,     mP4);
    checkVal({tag, ".valid"}, {31'b0, IFID_Valid},  {31'b0, mValid});
    checkVal({tag, ".mis"},   {31'b0, MisalignErr}, {31'b0, mMis});
    checkVal({tag, ".count"}, FetchCount,       mCnt);
  endtask

  task automatic modelReset();
    mPc = 32'h0; mIns = 32'h0; mP4 = 32'h0; mValid = 1'b0; mMis = 1'b0; mCnt = 32'h0;
  endtask

  // One clock edge of the fetch stage, described from its architectural rules.
  task automatic modelEdge();
    logic [31:0] t;
    if (Stall) begin
      mMis = 1'b0;
    end else if (JumpReg || Jump || Branch) begin
      t      = JumpReg ? JumpRegTarget : (Jump ? JumpTarget : BranchTarget);
      mMis   = (t % 4) != 0;
      mPc    = t - (t % 4);
      mIns   = 32'h0;
      mP4    = 32'h0;
      mValid = 1'b0;
    end else begin
      mIns   = mem[(mPc / 4) % 1024];
      mP4    = mPc + 32'd4;
      mPc    = mPc + 32'd4;
      mValid = 1'b1;
      mCnt   = mCnt + 32'd1;
      mMis   = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic br, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic jr, input logic [31:0] jrt);
    Stall = s; Branch = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
    JumpReg = jr; JumpRegTarget = jrt;
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    Rst_n = 1'b0;
    modelReset();
    #3;
    checkOutput("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    step("first");
    checkVal("first.instr_k", IFID_Instruction, 32'h2008_0001);
    checkVal("first.pc4_k", IFID_PCPlus4, 32'h4);
    step("second");
    checkVal("second.instr_k", IFID_Instruction, 32'h2009_0002);
    checkVal("second.count_k", FetchCount, 32'd2);
    step("seq3");
    step("seq4");
    checkVal("at10.addr_k", InstrAddr, 32'h10);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step("stall");
    checkVal("stall.addr_k", InstrAddr, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("resume");
    checkVal("resume.addr_k", InstrAddr, 32'h14);
    step("seq18");

    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    step("branch");
    checkVal("branch.addr_k", InstrAddr, 32'h40);
    checkVal("branch.valid_k", {31'b0, IFID_Valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("branch_land");
    checkVal("branch_land.instr_k", IFID_Instruction, mem[16]);
    checkVal("branch_land.pc4_k", IFID_PCPlus4, 32'h44);
    checkVal("branch_land.count_k", FetchCount, 32'd7);

    // Asynchronous reset between edges with a valid IF/ID entry.
    #2;
    Rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset");
    checkVal("midreset.count_k", FetchCount, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step("post_reset");

    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    step("j_over_br");
    checkVal("j_over_br.addr_k", InstrAddr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200);
    step("jr_over_j");
    checkVal("jr_over_j.addr_k", InstrAddr, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300);
    step("stall_jr");
    checkVal("stall_jr.addr_k", InstrAddr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h203);
    step("jr_mis");
    checkVal("jr_mis.addr_k", InstrAddr, 32'h200);
    checkVal("jr_mis.flag_k", {31'b0, MisalignErr}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("mis_clear");
    checkVal("mis_clear.flag_k", {31'b0, MisalignErr}, 32'h0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step("jump_top");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("wrap");
    checkVal("wrap.addr_k", InstrAddr, 32'h0);
    checkVal("wrap.pc4_k", IFID_PCPlus4, 32'h0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 4) == 0,
                    ($urandom % 6) == 0, $urandom,
                    ($urandom % 8) == 0, $urandom,
                    ($urandom % 10) == 0, $urandom);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
